// File: rtl/led_blinker_bank.sv
// Multi-channel LED sequencer: a shared prescaler tick drives per-channel
// off/on/blink/one-shot engines configured through a simple write port.
module led_blinker_bank #(
   parameter int unsigned NUM_CH      = 8,
   parameter int unsigned PRESCALE    = 100000,
   parameter int unsigned PER_W       = 16,
   parameter int unsigned DEFAULT_PER = 500,
   localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              en,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [1:0]        cfg_mode,
   input  logic [PER_W-1:0]  cfg_period,
   output logic              tick,
   output logic [NUM_CH-1:0] led
);

   localparam logic [1:0] MODE_OFF     = 2'd0;
   localparam logic [1:0] MODE_ON      = 2'd1;
   localparam logic [1:0] MODE_BLINK   = 2'd2;
   localparam logic [1:0] MODE_ONESHOT = 2'd3;

   localparam int unsigned    PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

   logic [PRE_W-1:0] pre_cnt;
   logic             pre_wrap;
   logic             adv;

   assign pre_wrap = (pre_cnt == PRE_LAST);
   // A tick that coincides with en=0 is dropped so that disabling freezes everything.
   assign adv      = tick & en;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         pre_cnt <= '0;
         tick    <= 1'b0;
      end else if (en) begin
         pre_cnt <= pre_wrap ? '0 : pre_cnt + 1'b1;
         tick    <= pre_wrap;
      end else begin
         tick    <= 1'b0;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [1:0]       mode_q, mode_d;
      logic [PER_W-1:0] per_q, per_d;
      logic [PER_W-1:0] cnt_q, cnt_d;
      logic [PER_W-1:0] last;
      logic             led_q, led_d;
      logic             wr_hit;

      // Out-of-range channel numbers never match any instance, so they are ignored.
      assign wr_hit = cfg_we && (cfg_ch == CH_W'(i));
      // Period 0 behaves as 1, so the terminal count is 0 in both cases.
      assign last   = (per_q == '0) ? '0 : per_q - 1'b1;

      always_comb begin
         mode_d = mode_q;
         per_d  = per_q;
         cnt_d  = cnt_q;
         led_d  = led_q;
         if (wr_hit) begin
            mode_d = cfg_mode;
            per_d  = cfg_period;
            cnt_d  = '0;
            led_d  = (cfg_mode == MODE_ON) || (cfg_mode == MODE_ONESHOT);
         end else if (adv) begin
            unique case (mode_q)
               MODE_OFF: begin
                  cnt_d = '0;
                  led_d = 1'b0;
               end
               MODE_ON: begin
                  cnt_d = '0;
                  led_d = 1'b1;
               end
               MODE_BLINK: begin
                  if (cnt_q == last) begin
                     cnt_d = '0;
                     led_d = ~led_q;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
               MODE_ONESHOT: begin
                  if (cnt_q == last) begin
                     cnt_d  = '0;
                     led_d  = 1'b0;
                     mode_d = MODE_OFF;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
               default: cnt_d = '0;
            endcase
         end
      end

      always_ff @(posedge sys_clk or posedge sys_rst) begin
         if (sys_rst) begin
            mode_q <= MODE_BLINK;
            per_q  <= PER_W'(DEFAULT_PER);
            cnt_q  <= '0;
            led_q  <= 1'b0;
         end else begin
            mode_q <= mode_d;
            per_q  <= per_d;
            cnt_q  <= cnt_d;
            led_q  <= led_d;
         end
      end

      assign led[i] = led_q;
   end

endmodule
